// File: rtl/instr_encoder_if.sv
// Request and imem-write bundle between an instruction source and instr_encoder.
// The master side issues field-level requests; the slave side is the encoder.
interface instr_encoder_if #(
    parameter int unsigned ADDR_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [4:0]        in_shamt;
    logic [5:0]        in_funct;
    logic [25:0]       in_imm;
    logic              flush;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              err_op;
    logic              done;

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, flush,
        input  in_ready, imem_we, imem_addr, imem_wdata, count, err_op, done
    );

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, flush,
        output in_ready, imem_we, imem_addr, imem_wdata, count, err_op, done
    );
endinterface

// File: rtl/instr_encoder.sv
// Boot loader: encodes field-level requests into MIPS words and writes them
// sequentially into imem, one cycle after each accept.
module instr_encoder #(
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic            clk,
    input  logic            rst,
    instr_encoder_if.slave  bus
);
    localparam logic [ADDR_W:0] Capacity = (ADDR_W+1)'(2**ADDR_W);

    typedef enum logic [1:0] {StRun, StFull, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              accept;
    logic [31:0]       enc;

    always_comb begin
        enc = '0;
        case (bus.in_op)
            3'd0:    enc = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, bus.in_funct};
            3'd1:    enc = {6'h23, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
            3'd2:    enc = {6'h2B, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
            3'd3:    enc = {6'h04, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
            3'd4:    enc = {6'h08, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
            3'd5:    enc = {6'h02, bus.in_imm};
            3'd6:    enc = {6'h03, bus.in_imm};
            default: enc = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        accept  = bus.in_valid && (state_q == StRun);

        if (accept) begin
            if (bus.in_op == 3'd7) begin
                err_d = 1'b1;
            end else begin
                we_d    = 1'b1;
                addr_d  = ptr_q;
                wdata_d = enc;
                ptr_d   = ptr_q + ADDR_W'(1);
                count_d = count_q + (ADDR_W+1)'(1);
            end
        end

        // Filling the memory takes precedence over a simultaneous flush; both halt the loader.
        if (state_q == StRun) begin
            if (count_d == Capacity) begin
                state_d = StFull;
            end else if (bus.flush) begin
                state_d = StDone;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            ptr_q   <= ADDR_W'(BASE_ADDR);
            count_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready   = (state_q == StRun);
    assign bus.done       = (state_q != StRun);
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.count      = count_q;
    assign bus.err_op     = err_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a 64-word instance for encoding, flush,
// reserved-op and reset cases, and a 4-word instance for the memory-full case.
module tb_instr_encoder;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cnt_a = 0;
    int   cnt_b = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(6)) bus_a ();
    instr_encoder_if #(.ADDR_W(2)) bus_b ();

    instr_encoder #(.ADDR_W(6), .BASE_ADDR(0)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
    instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitors: every imem write must match the oldest expected entry.
    always @(negedge clk) begin
        if (bus_a.imem_we === 1'b1) begin
            if (q_a.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL a_write: unexpected write addr %h data %h",
                         bus_a.imem_addr, bus_a.imem_wdata);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                check("a_addr", 32'(bus_a.imem_addr), e.addr);
                check("a_data", bus_a.imem_wdata, e.data);
                check("a_count", 32'(bus_a.count), e.cnt);
            end
        end
    end

    always @(negedge clk) begin
        if (bus_b.imem_we === 1'b1) begin
            if (q_b.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL b_write: unexpected write addr %h data %h",
                         bus_b.imem_addr, bus_b.imem_wdata);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                check("b_addr", 32'(bus_b.imem_addr), e.addr);
                check("b_data", bus_b.imem_wdata, e.data);
                check("b_count", 32'(bus_b.count), e.cnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                          input logic [25:0] imm, input logic fl, input logic [31:0] exp);
        bus_a.in_valid = 1'b1;
        bus_a.in_op    = op;
        bus_a.in_rs    = rs;
        bus_a.in_rt    = rt;
        bus_a.in_rd    = rd;
        bus_a.in_shamt = sh;
        bus_a.in_funct = fn;
        bus_a.in_imm   = imm;
        bus_a.flush    = fl;
        if (bus_a.in_ready === 1'b1 && op != 3'd7) begin
            q_a.push_back('{addr: 32'(cnt_a % 64), data: exp, cnt: 32'(cnt_a + 1)});
            cnt_a++;
        end
        tick();
        bus_a.flush = 1'b0;
    endtask

    task automatic send_b(input logic [4:0] rt, input logic [25:0] imm, input logic [31:0] exp);
        bus_b.in_valid = 1'b1;
        bus_b.in_op    = 3'd4;
        bus_b.in_rs    = 5'd0;
        bus_b.in_rt    = rt;
        bus_b.in_rd    = 5'd0;
        bus_b.in_shamt = 5'd0;
        bus_b.in_funct = 6'd0;
        bus_b.in_imm   = imm;
        if (bus_b.in_ready === 1'b1) begin
            q_b.push_back('{addr: 32'(cnt_b % 4), data: exp, cnt: 32'(cnt_b + 1)});
            cnt_b++;
        end
        tick();
    endtask

    task automatic idle_a(input int n);
        bus_a.in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic reset_a();
        bus_a.in_valid = 1'b0;
        rst_a = 1'b1;
        repeat (2) tick();
        rst_a = 1'b0;
        cnt_a = 0;
    endtask

    initial begin
        bus_a.in_valid = 1'b0; bus_a.in_op = '0; bus_a.in_rs = '0; bus_a.in_rt = '0;
        bus_a.in_rd = '0; bus_a.in_shamt = '0; bus_a.in_funct = '0; bus_a.in_imm = '0;
        bus_a.flush = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_op = '0; bus_b.in_rs = '0; bus_b.in_rt = '0;
        bus_b.in_rd = '0; bus_b.in_shamt = '0; bus_b.in_funct = '0; bus_b.in_imm = '0;
        bus_b.flush = 1'b0;
        #1;
        reset_a();
        rst_b = 1'b0;

        check("rst_ready", 32'(bus_a.in_ready), 32'd1);
        check("rst_done", 32'(bus_a.done), 32'd0);
        check("rst_err", 32'(bus_a.err_op), 32'd0);
        check("rst_we", 32'(bus_a.imem_we), 32'd0);
        check("rst_count", 32'(bus_a.count), 32'd0);
        check("rst_addr", 32'(bus_a.imem_addr), 32'd0);
        check("rst_wdata", bus_a.imem_wdata, 32'd0);

        // ADDI with junk in unused fields, then J.
        send_a(3'd4, 5'd0, 5'd8, 5'd31, 5'd31, 6'h3F, 26'h3FF0005, 1'b0, 32'h20080005);
        send_a(3'd5, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 26'h0123456, 1'b0, 32'h08123456);
        idle_a(3);
        check("hold_addr", 32'(bus_a.imem_addr), 32'd1);
        check("hold_wdata", bus_a.imem_wdata, 32'h08123456);

        // Back-to-back RTYPE, LW, JAL.
        reset_a();
        send_a(3'd0, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 26'h3FFFFFF, 1'b0, 32'h012A4020);
        send_a(3'd1, 5'd29, 5'd8, 5'd0, 5'd0, 6'h00, 26'h0000004, 1'b0, 32'h8FA80004);
        send_a(3'd6, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 26'h0000010, 1'b0, 32'h0C000010);
        idle_a(3);
        check("t2_count", 32'(bus_a.count), 32'd3);
        check("t2_hold_wdata", bus_a.imem_wdata, 32'h0C000010);

        // Reserved op between two SWs.
        reset_a();
        send_a(3'd2, 5'd29, 5'd9, 5'd0, 5'd0, 6'h00, 26'h0000008, 1'b0, 32'hAFA90008);
        check("t4_err_before", 32'(bus_a.err_op), 32'd0);
        send_a(3'd7, 5'd1, 5'd1, 5'd1, 5'd1, 6'h01, 26'h0000001, 1'b0, 32'h0);
        check("t4_err_after", 32'(bus_a.err_op), 32'd1);
        send_a(3'd2, 5'd0, 5'd10, 5'd0, 5'd0, 6'h00, 26'h000FFFC, 1'b0, 32'hAC0AFFFC);
        idle_a(3);
        check("t4_count", 32'(bus_a.count), 32'd2);
        check("t4_err_sticky", 32'(bus_a.err_op), 32'd1);

        // Flush together with an accepted BEQ.
        reset_a();
        send_a(3'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 26'h000FFFF, 1'b1, 32'h1022FFFF);
        check("t5_done", 32'(bus_a.done), 32'd1);
        check("t5_ready", 32'(bus_a.in_ready), 32'd0);
        send_a(3'd4, 5'd0, 5'd3, 5'd0, 5'd0, 6'h00, 26'h0000001, 1'b0, 32'h20030001);
        idle_a(3);
        check("t5_count", 32'(bus_a.count), 32'd1);
        check("t5_done_hold", 32'(bus_a.done), 32'd1);

        // Reset the cycle after an accept.
        reset_a();
        send_a(3'd4, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00, 26'h0000005, 1'b0, 32'h20080005);
        bus_a.in_valid = 1'b0;
        rst_a = 1'b1;
        tick();
        check("t6_we", 32'(bus_a.imem_we), 32'd0);
        check("t6_count", 32'(bus_a.count), 32'd0);
        check("t6_ready", 32'(bus_a.in_ready), 32'd1);
        rst_a = 1'b0;
        cnt_a = 0;
        send_a(3'd4, 5'd0, 5'd9, 5'd0, 5'd0, 6'h00, 26'h0000007, 1'b0, 32'h20090007);
        idle_a(3);

        // 4-word memory: five requests, only four land.
        send_b(5'd1, 26'h0000000, 32'h20010000);
        send_b(5'd2, 26'h0000001, 32'h20020001);
        send_b(5'd3, 26'h0000002, 32'h20030002);
        send_b(5'd4, 26'h0000003, 32'h20040003);
        check("t3_ready_low", 32'(bus_b.in_ready), 32'd0);
        send_b(5'd5, 26'h0000004, 32'h20050004);
        bus_b.in_valid = 1'b0;
        bus_b.flush = 1'b1;
        repeat (3) tick();
        bus_b.flush = 1'b0;
        check("t3_done", 32'(bus_b.done), 32'd1);
        check("t3_count", 32'(bus_b.count), 32'd4);
        check("t3_ready_stays_low", 32'(bus_b.in_ready), 32'd0);

        check("a_queue_drained", 32'(q_a.size()), 32'd0);
        check("b_queue_drained", 32'(q_b.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
